// File: rtl/fetch_queue_unit_if.sv
// Decode-side bundle of the fetch stage: instruction handshake toward decode
// plus the redirect request coming back from execute.
interface fetch_queue_unit_if;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    input  instr_ready, redirect, redirect_pc,
    output instr_valid, instr, instr_pc
  );

  modport slave (
    output instr_ready, redirect, redirect_pc,
    input  instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC generator, one-deep in-flight read tracking and a
// DEPTH-entry prefetch queue feeding decode, with redirect squash.
module memory #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 18
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] in,
  output logic [DATAWIDTH-1:0] out
);
  logic [DATAWIDTH-1:0] r_mem [0:(1<<ADDRWIDTH)-1];
  logic [DATAWIDTH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (write) r_mem[addr] <= in;
    r_out <= r_mem[addr];
  end

  assign out = r_out;
endmodule

module fetch_queue_unit #(
  parameter int          ADDRWIDTH = 18,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  fetch_queue_unit_if.master bus
);
  localparam int              PTRW     = $clog2(DEPTH);
  localparam logic [31:0]     START_PC = RESET_PC & ~32'd3;
  localparam logic [PTRW+1:0] DEPTH_C  = (PTRW+2)'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW:0]   r_count;
  logic [31:0]     r_q_instr [DEPTH];
  logic [31:0]     r_q_pc    [DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [31:0]     w_issue_pc;
  logic [31:0]     w_mem_data;
  logic [PTRW+1:0] w_credit;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.instr_ready;
  assign w_push     = r_inflight & ~bus.redirect;
  // Slots already promised (queued + in flight) after this cycle's pop.
  assign w_credit   = {1'b0, r_count} + {{(PTRW+1){1'b0}}, r_inflight}
                    - {{(PTRW+1){1'b0}}, w_pop};
  assign w_issue    = bus.redirect | (w_credit < DEPTH_C);
  assign w_issue_pc = bus.redirect ? (bus.redirect_pc & ~32'd3) : r_fetch_pc;

  memory #(
    .DATAWIDTH (32),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_mem (
    .clk   (clk),
    .write (1'b0),
    .addr  (w_issue_pc[ADDRWIDTH+1:2]),
    .in    (32'd0),
    .out   (w_mem_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= START_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= START_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_issue_pc + 32'd4;
        r_inflight_pc <= w_issue_pc;
      end
      // A redirect empties the queue; the concurrent return is simply not pushed.
      if (bus.redirect) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (!w_push && w_pop)
          r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry contents need no reset: they are only observed while instr_valid = 1.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= w_mem_data;
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_q_instr[r_rd_ptr];
  assign bus.instr_pc    = r_q_pc[r_rd_ptr];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: per-cycle vector table plus an in-order PC/data
// scoreboard, with hand sequences for async reset and PC wrap.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_w = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_unit_if f ();
  fetch_queue_unit_if fw ();

  fetch_queue_unit #(.ADDRWIDTH(18), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(f)
  );

  fetch_queue_unit #(.ADDRWIDTH(8), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_w), .bus(fw)
  );

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl [26];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];

  function automatic vec_t mk(input logic r, input logic d, input logic [31:0] p,
                              input logic v, input logic [31:0] e);
    vec_t t;
    t.ready = r; t.redir = d; t.rpc = p; t.exp_v = v; t.exp_pc = e;
    return t;
  endfunction

  function automatic logic [31:0] word_main(input logic [31:0] pc);
    return 32'hA000_0000 + {14'd0, pc[19:2]};
  endfunction

  function automatic logic [31:0] word_wrap(input logic [31:0] pc);
    return 32'hA000_0000 + {24'd0, pc[9:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_fill(input logic [31:0] base, input int n);
    sb.delete();
    for (int k = 0; k < n; k++) sb.push_back(base + 32'(4 * k));
  endtask

  // One main-DUT cycle: optional output check, scoreboard on handshake, overflow guard.
  task automatic tick(input bit do_chk, input logic exp_v, input logic [31:0] exp_pc,
                      input string tag);
    logic [31:0] e;
    @(negedge clk);
    if (do_chk) begin
      chk({tag, "_valid"}, {31'd0, f.instr_valid}, {31'd0, exp_v});
      if (exp_v) chk({tag, "_pc"}, f.instr_pc, exp_pc);
    end
    if (rst_n && f.instr_valid && f.instr_ready) begin
      $display("pop pc=%h instr=%h", f.instr_pc, f.instr);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got pc %h expected no entry", f.instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", f.instr_pc, e);
        chk("sb_instr", f.instr, word_main(e));
      end
    end
    checks++;
    if (int'(dut.r_count) > DEPTH) begin
      errors++;
      $display("FAIL overflow: count %0d expected at most %0d", dut.r_count, DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    f.instr_ready  = 1'b1;
    f.redirect     = 1'b0;
    f.redirect_pc  = 32'd0;
    fw.instr_ready = 1'b1;
    fw.redirect    = 1'b0;
    fw.redirect_pc = 32'd0;

    for (int i = 0; i < 1024; i++) dut.u_mem.r_mem[i] <= 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 256; i++)  dut_w.u_mem.r_mem[i] <= 32'hA000_0000 + 32'(i);

    tbl[0]  = mk(1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 32'h000);
    tbl[3]  = mk(1, 0, 0, 1, 32'h004);
    tbl[4]  = mk(1, 0, 0, 1, 32'h008);
    tbl[5]  = mk(1, 0, 0, 1, 32'h00C);
    tbl[6]  = mk(0, 0, 0, 1, 32'h010);
    tbl[7]  = mk(0, 0, 0, 1, 32'h010);
    tbl[8]  = mk(0, 0, 0, 1, 32'h010);
    tbl[9]  = mk(0, 0, 0, 1, 32'h010);
    tbl[10] = mk(0, 0, 0, 1, 32'h010);
    tbl[11] = mk(1, 0, 0, 1, 32'h010);
    tbl[12] = mk(1, 0, 0, 1, 32'h014);
    tbl[13] = mk(1, 0, 0, 1, 32'h018);
    tbl[14] = mk(1, 0, 0, 1, 32'h01C);
    tbl[15] = mk(0, 0, 0, 1, 32'h020);
    tbl[16] = mk(0, 1, 32'h0000_0103, 1, 32'h020);
    tbl[17] = mk(0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 1, 32'h100);
    tbl[19] = mk(1, 0, 0, 1, 32'h104);
    tbl[20] = mk(1, 1, 32'h0000_0200, 1, 32'h108);
    tbl[21] = mk(1, 1, 32'h0000_0300, 0, 0);
    tbl[22] = mk(1, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 1, 32'h300);
    tbl[24] = mk(1, 0, 0, 1, 32'h304);
    tbl[25] = mk(1, 0, 0, 1, 32'h308);

    // Reset state on both instances.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, f.instr_valid}, 32'd0);
      chk("rst_valid_w", {31'd0, fw.instr_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_fill(32'h0, 16);

    for (int i = 0; i < 26; i++) begin
      f.instr_ready = tbl[i].ready;
      f.redirect    = tbl[i].redir;
      f.redirect_pc = tbl[i].rpc;
      tick(1'b1, tbl[i].exp_v, tbl[i].exp_pc, $sformatf("v%0d", i));
      if (tbl[i].redir) sb_fill(tbl[i].rpc & ~32'd3, 8);
    end
    f.redirect    = 1'b0;
    f.redirect_pc = 32'd0;

    // Build count = 3, then drop reset between clock edges.
    f.instr_ready = 1'b0;
    tick(1'b1, 1'b1, 32'h30C, "hold0");
    tick(1'b1, 1'b1, 32'h30C, "hold1");
    chk("pre_rst_count", {29'd0, dut.r_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, f.instr_valid}, 32'd0);
    tick(1'b1, 1'b0, 32'd0, "in_rst");
    rst_n = 1'b1;
    sb_fill(32'h0, 16);

    // Restart with back-pressure: queue fills with 0..12, then drains without gaps.
    for (int k = 0; k < 12; k++) tick(1'b1, (k >= 2), 32'h0, $sformatf("bp%0d", k));
    chk("bp_full_count", {29'd0, dut.r_count}, 32'd4);
    f.instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 32'(4 * k), $sformatf("drain%0d", k));

    // PC wrap on the small-memory instance.
    rst_w = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] epc;
      epc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
      @(negedge clk);
      chk($sformatf("wrap%0d_valid", k), {31'd0, fw.instr_valid}, {31'd0, (k >= 2)});
      if (k >= 2) begin
        $display("wrap pc=%h instr=%h", fw.instr_pc, fw.instr);
        chk($sformatf("wrap%0d_pc", k), fw.instr_pc, epc);
        chk($sformatf("wrap%0d_instr", k), fw.instr, word_wrap(epc));
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage with a PC register, a sequential next-PC generator, branch/jump redirect and a DEPTH-entry prefetch queue. It sits between the instruction memory and decode. It issues one word-aligned read per cycle while queue credit is available, and delivers instructions with their PCs to decode over a valid/ready handshake. On redirect it squashes all wrong-path work.

## Interface
- ADDRWIDTH, 18: word-address bits into instruction memory. Memory size is 2^ADDRWIDTH words, indexed by pc[ADDRWIDTH+1:2].
- DEPTH, 4: prefetch queue entries. Must be a power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset. Low 2 bits are ignored.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_ready  in  1  decode accepts the head entry this cycle.
- redirect  in  1  taken branch/jump/exception: discard the queue and in-flight read; fetch from redirect_pc.
- redirect_pc  in  32  redirect target. Bits [1:0] are ignored.
- instr_valid  out  1  instr/instr_pc hold a valid entry.
- instr  out  32  instruction word at the queue head.
- instr_pc  out  32  byte PC of instr, with bits [1:0] = 0.

## Operation
- Instruction memory uses the codebase `memory` primitive: DATAWIDTH 32, ADDRWIDTH=ADDRWIDTH, write tied 0, in tied 0. It has a synchronous read with 1-cycle latency.
- Internal state:
  - fetch_pc: next address to issue.
  - inflight: 1-bit valid, with inflight_pc.
  - Circular queue of {instr, pc}: rd_ptr, wr_ptr, count of 0..DEPTH.
- Issue rule:
  - Memory address = redirect ? redirect_pc : fetch_pc.
  - A read issues in a cycle when redirect = 1, or when count + inflight − pop < DEPTH.
  - pop = instr_valid & instr_ready.
  - On issue: fetch_pc ← issued address + 4, mod 2^32. inflight ← 1, inflight_pc ← issued address.
  - When no read issues: fetch_pc holds and inflight ← 0.
- Return: when inflight = 1 and redirect = 0, the memory output and inflight_pc are written at wr_ptr. count increments, unless a pop happens in the same cycle.
- Push and pop in the same cycle are legal. count is unchanged and both pointers advance.
- The queue can never overflow, because the issue credit guarantees a slot. Overflow is an assertion failure in verification.
- Redirect (cycle T):
  - Queue flushed at the end of T: rd_ptr = wr_ptr, count = 0.
  - The return arriving in T is dropped.
  - The read issued in T is for redirect_pc, and it is kept.
  - A pop in T is honoured; decode sees the entry as consumed, and redirect_pc then owns the stream.
- instr_valid = (count ≠ 0). instr and instr_pc come from the entry at rd_ptr, combinationally.
- PC wrap: fetch_pc 32'hFFFF_FFFC → 32'h0000_0000. The memory index wraps modulo 2^ADDRWIDTH words (upper PC bits alias).

## Timing
- Reset values while rst_n = 0:
  - fetch_pc = RESET_PC & ~3, count = 0, pointers = 0, inflight = 0.
  - Outputs: instr_valid = 0. instr and instr_pc read entry 0, whose contents are don't-care while instr_valid = 0.
- Reset mid-operation discards all queue and in-flight state immediately (asynchronous).
- Cycle 0 is the first rising edge with rst_n = 1:
  - Cycle 0: RESET_PC is issued.
  - Cycle 1: its data is captured at the end of cycle 1.
  - Cycle 2: instr_valid = 1.
  - Issue-to-visible latency is 2 cycles.
- Throughput: one instruction per cycle sustained when instr_ready is held 1.
- Back-pressure: with instr_ready = 0 from the start, the queue fills to DEPTH with RESET_PC .. RESET_PC+4·(DEPTH−1), and issue stops. When instr_ready rises, entries drain 1 per cycle with no bubbles, because refill reads issue in the first pop cycle.
- Redirect asserted in cycle T: instr_valid = 0 in T+1, and the target instruction is visible in T+2.
- Back-to-back redirects in T and T+1: the second redirect wins, and its target is visible in T+3.

## Test plan
- Reset/stream: memory word i = 32'hA000_0000 + i, RESET_PC = 0, instr_ready = 1 → instr_valid rises in cycle 2 and pairs (0, A0000000), (4, A0000001), … appear one per cycle with no gaps.
- Full queue, DEPTH = 4: instr_ready = 0 for 10 cycles → count = 4 and PCs 0..12 are queued. Release → PCs 0, 4, 8, 12, 16 appear in consecutive cycles with no duplicates or gaps.
- Redirect while full: redirect = 1, redirect_pc = 32'h0000_0103 in cycle T → instr_valid = 0 in T+1; instr_pc = 32'h100 in T+2, then 32'h104.
- Redirect with pop and return in the same cycle → the popped entry is counted once, the in-flight return is dropped, and no stale PC appears after T.
- Wrap: RESET_PC = 32'hFFFF_FFF8 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, and the data matches memory words 2^ADDRWIDTH−2, 2^ADDRWIDTH−1, 0.
- Async reset mid-stream: drop rst_n between clock edges with count = 3 → instr_valid = 0 immediately. After release, the stream restarts from RESET_PC with cycle-2 latency.
